// File: rtl/prbs26_checker.sv
// prbs26_checker: self-synchronising checker for the 26-bit LFSR bit stream.
// It fills a shadow register from the stream and verifies the predictions
// until lock. While locked it counts mismatches against the predicted sequence.
// Optional build macro PRBS_LOCK_LOSS_EN adds windowed lock-loss detection.
// When that macro is undefined, LOCKED is left only through rst.
module prbs26_checker #(
  parameter logic [25:0] TAPS       = 26'h2000023,
  parameter int unsigned LOCK_CNT   = 32,
  parameter int unsigned WIN        = 64,
  parameter int unsigned ERR_THRESH = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_cnt,
  input  logic             bit_in,
  input  logic             bit_vld,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_VERIFY = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  localparam logic [4:0] FILL_LAST = 5'd25;
  localparam logic [7:0] LOCK_LAST = 8'(LOCK_CNT - 1);

  // Reject out-of-range configurations at elaboration
  if (LOCK_CNT < 1 || LOCK_CNT > 255 || WIN < 2 || WIN > 65535 ||
      ERR_THRESH < 1 || ERR_THRESH > WIN || CNT_W < 1) begin : g_bad_cfg
    $fatal(1, "prbs26_checker: parameter out of range");
  end

  state_t     st;
  logic [25:0] sr;        // sr[0] holds the newest bit (sr[1] in tap numbering)
  logic [4:0]  fill_cnt;
  logic [7:0]  match_cnt;
  logic        pred;
  logic        mis;
  logic        err_hit;

  assign pred    = ^(sr & TAPS);
  assign mis     = bit_in ^ pred;
  assign err_hit = bit_vld && (st == S_LOCKED) && mis;
  assign state   = st;

`ifdef PRBS_LOCK_LOSS_EN
  localparam logic [15:0] WIN_LAST = 16'(WIN - 1);
  localparam logic [15:0] THR_LAST = 16'(ERR_THRESH - 1);

  logic [15:0] win_cnt;
  logic [15:0] win_err;
`endif

  // Sync state machine: fill, verify predictions, then track while locked
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= S_FILL;
      sr        <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      locked    <= 1'b0;
`ifdef PRBS_LOCK_LOSS_EN
      win_cnt   <= '0;
      win_err   <= '0;
`endif
    end else if (bit_vld) begin
      case (st)
        S_FILL: begin
          sr <= {sr[24:0], bit_in};
          if (fill_cnt == FILL_LAST) begin
            st        <= S_VERIFY;
            fill_cnt  <= '0;
            match_cnt <= '0;
          end else begin
            fill_cnt <= fill_cnt + 5'd1;
          end
        end
        S_VERIFY: begin
          sr <= {sr[24:0], bit_in};
          // An all-zero register predicts zeros forever, so it must never count as sync
          if ((sr == '0) || mis) begin
            st       <= S_FILL;
            fill_cnt <= '0;
          end else if (match_cnt == LOCK_LAST) begin
            st     <= S_LOCKED;
            locked <= 1'b1;
`ifdef PRBS_LOCK_LOSS_EN
            win_cnt <= '0;
            win_err <= '0;
`endif
          end else begin
            match_cnt <= match_cnt + 8'd1;
          end
        end
        S_LOCKED: begin
          // Shifting the prediction keeps one channel error from echoing through the taps
          sr <= {sr[24:0], pred};
`ifdef PRBS_LOCK_LOSS_EN
          if (mis && (win_err == THR_LAST)) begin
            st       <= S_FILL;
            locked   <= 1'b0;
            fill_cnt <= '0;
          end else if (win_cnt == WIN_LAST) begin
            win_cnt <= '0;
            win_err <= '0;
          end else begin
            win_cnt <= win_cnt + 16'd1;
            win_err <= win_err + 16'(mis);
          end
`endif
        end
        default: begin
          st       <= S_FILL;
          fill_cnt <= '0;
          locked   <= 1'b0;
        end
      endcase
    end
  end

  // Error pulse and saturating error counter; clear has priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err_pulse <= err_hit;
      if (clr_cnt) begin
        err_cnt <= '0;
      end else if (err_hit && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prbs26_checker.sv
// tb_prbs26_checker: directed scoreboard bench for prbs26_checker (CNT_W=4).
// Expected outputs come from the stream position, the injected errors and
// the lock/window rules. Results follow PRBS_LOCK_LOSS_EN when it is defined.
module tb_prbs26_checker;

  localparam logic [25:0] TAPS = 26'h2000023;
  localparam logic [25:0] SEED = 26'b10_1111_0001_0001_0001_0010_1101;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr_cnt;
  logic       bit_in;
  logic       bit_vld;
  logic       locked;
  logic       err_pulse;
  logic [3:0] err_cnt;
  logic [1:0] state;

  always #5 clk = ~clk;

  prbs26_checker #(.CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr_cnt   (clr_cnt),
    .bit_in    (bit_in),
    .bit_vld   (bit_vld),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
    .state     (state)
  );

  typedef struct packed {
    logic       lk;
    logic       pulse;
    logic [3:0] cnt;
    logic [1:0] st;
    logic       st_any;  // only require state != LOCKED
  } exp_t;

  exp_t sb[$];

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  logic [25:0] gen;
  int          sync_n;
  logic        m_lk;
  logic [3:0]  m_cnt;
  logic [1:0]  m_st;
  int          win_n;
  int          werr;
  logic        zero_mode;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic gen_bit(output logic b);
    b   = ^(gen & TAPS);
    gen = {gen[24:0], b};
  endtask

  task automatic step(input logic b, input logic v, input logic corrupt, input logic clr);
    exp_t e;
    exp_t got;
    bit_in  = b ^ corrupt;
    bit_vld = v;
    clr_cnt = clr;
    e.pulse = 1'b0;
    if (v && !zero_mode) begin
      if (!m_lk) begin
        sync_n++;
        m_st = (sync_n < 26) ? 2'd0 : ((sync_n < 58) ? 2'd1 : 2'd2);
        if (sync_n == 58) begin
          m_lk  = 1'b1;
          win_n = 0;
          werr  = 0;
        end
      end else begin
        if (corrupt) begin
          e.pulse = 1'b1;
          if (m_cnt != 4'hF) m_cnt++;
        end
        win_n++;
        if (corrupt) werr++;
`ifdef PRBS_LOCK_LOSS_EN
        if (werr == 8) begin
          m_lk   = 1'b0;
          m_st   = 2'd0;
          sync_n = 0;
        end else
`endif
        if (win_n == 64) begin
          win_n = 0;
          werr  = 0;
        end
      end
    end
    if (clr) m_cnt = '0;
    e.lk     = m_lk;
    e.cnt    = m_cnt;
    e.st     = m_st;
    e.st_any = zero_mode;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("locked", locked, got.lk);
    chk("err_pulse", err_pulse, got.pulse);
    chk("err_cnt", err_cnt, got.cnt);
    if (got.st_any) chk("state_not_locked", state != 2'd2, 1'b1);
    else            chk("state", state, got.st);
    if (err_pulse === 1'b1) pulses++;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bit_vld = 1'b0;
    clr_cnt = 1'b0;
    bit_in  = 1'b0;
    #2;
    chk("rst_locked", locked, 1'b0);
    chk("rst_err_pulse", err_pulse, 1'b0);
    chk("rst_err_cnt", err_cnt, 4'd0);
    chk("rst_state", state, 2'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    sync_n    = 0;
    m_lk      = 1'b0;
    m_cnt     = '0;
    m_st      = 2'd0;
    win_n     = 0;
    werr      = 0;
    zero_mode = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic b;
    gen = SEED;
    do_reset();

    // Clean sync then a long clean run
    for (int i = 0; i < 58; i++) begin gen_bit(b); step(b, 1'b1, 1'b0, 1'b0); end
    chk("clean_locked", locked, 1'b1);
    for (int i = 0; i < 1000; i++) begin gen_bit(b); step(b, 1'b1, 1'b0, 1'b0); end
    chk("clean_err_cnt", err_cnt, 4'd0);

    // Single channel error gives exactly one pulse
    pulses = 0;
    gen_bit(b); step(b, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) begin gen_bit(b); step(b, 1'b1, 1'b0, 1'b0); end
    chk("single_pulses", pulses, 1);
    chk("single_err_cnt", err_cnt, 4'd1);
    chk("single_locked", locked, 1'b1);

    // Saturation at 15, then clear, then clear racing an error
    for (int k = 0; k < 20; k++) begin
      gen_bit(b); step(b, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 9; i++) begin gen_bit(b); step(b, 1'b1, 1'b0, 1'b0); end
    end
    chk("sat_err_cnt", err_cnt, 4'hF);
    for (int i = 0; i < 10; i++) begin gen_bit(b); step(b, 1'b1, 1'b0, 1'b0); end
    chk("sat_hold", err_cnt, 4'hF);
    gen_bit(b); step(b, 1'b1, 1'b0, 1'b1);
    chk("clr_err_cnt", err_cnt, 4'd0);
    chk("clr_locked", locked, 1'b1);
    gen_bit(b); step(b, 1'b1, 1'b1, 1'b1);
    chk("clr_wins_cnt", err_cnt, 4'd0);
    chk("clr_wins_pulse", err_pulse, 1'b1);
    for (int i = 0; i < 9; i++) begin gen_bit(b); step(b, 1'b1, 1'b0, 1'b0); end
    gen_bit(b); step(b, 1'b1, 1'b1, 1'b0);
    chk("post_clr_inc", err_cnt, 4'd1);

    // Reset while locked returns everything to reset values
    do_reset();

    // Gapped valid: invalid cycles carry random data that must be ignored
    for (int i = 0; i < 58; i++) begin
      gen_bit(b); step(b, 1'b1, 1'b0, 1'b0);
      step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
    end
    chk("gapped_locked", locked, 1'b1);
    for (int i = 0; i < 40; i++) begin
      gen_bit(b); step(b, 1'b1, 1'b0, 1'b0);
      step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
    end
    chk("gapped_err_cnt", err_cnt, 4'd0);

    // All-zero stream never locks
    do_reset();
    zero_mode = 1'b1;
    for (int i = 0; i < 500; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("zero_locked", locked, 1'b0);

    // Eight errors inside the first window after lock
    do_reset();
    for (int i = 0; i < 58; i++) begin gen_bit(b); step(b, 1'b1, 1'b0, 1'b0); end
    chk("ll_pre_locked", locked, 1'b1);
    for (int k = 0; k < 8; k++) begin
      if (k != 0) for (int i = 0; i < 4; i++) begin gen_bit(b); step(b, 1'b1, 1'b0, 1'b0); end
      gen_bit(b); step(b, 1'b1, 1'b1, 1'b0);
    end
    chk("ll_err_cnt", err_cnt, 4'd8);
`ifdef PRBS_LOCK_LOSS_EN
    chk("ll_locked_drop", locked, 1'b0);
    chk("ll_state_fill", state, 2'd0);
`else
    chk("ll_locked_kept", locked, 1'b1);
    chk("ll_state_locked", state, 2'd2);
`endif
    for (int i = 0; i < 58; i++) begin gen_bit(b); step(b, 1'b1, 1'b0, 1'b0); end
    chk("ll_relocked", locked, 1'b1);
    chk("ll_cnt_kept", err_cnt, 4'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
